// File: rtl/daq_read_seq_if.sv
// daq_read_seq_if: sample hand-off port from the read sequencer to the sample FIFO.
// Signal names are written from the sequencer's side; the master modport is the sequencer.
interface daq_read_seq_if #(
    parameter int DW = 16,
    parameter int CW = 3
);
    logic [DW-1:0] dout_o;
    logic [CW-1:0] dout_chan_o;
    logic          dout_valid_o;
    logic          dout_ready_i;

    modport master (output dout_o, dout_chan_o, dout_valid_o, input dout_ready_i);
    modport slave  (input dout_o, dout_chan_o, dout_valid_o, output dout_ready_i);
endinterface

// File: rtl/daq_read_seq.sv
// daq_read_seq: frame-bounded ADC readout; waits for the busy pulse, then issues NCHAN read strobes.
// Optional busy watchdog (BUSY_TO parameter, timeout_o) is built only with DAQ_RDSEQ_TIMEOUT_EN defined.
module daq_read_seq #(
`ifdef DAQ_RDSEQ_TIMEOUT_EN
    parameter int BUSY_TO = 255,
`endif
    parameter int NCHAN = 8,
    parameter int DW    = 16,
    parameter int TLOW  = 3,
    parameter int THIGH = 2,
    localparam int CW   = NCHAN > 1 ? $clog2(NCHAN) : 1,
    localparam int TMAX = TLOW > THIGH ? TLOW : THIGH,
    localparam int TW   = $clog2(TMAX + 1)
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            start_i,
    input  logic            busy_i,
    input  logic [DW-1:0]   data_i,
    output logic            rd_n_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            overrun_o,
    output logic            timeout_o,
    daq_read_seq_if.master  out_if
);
    typedef enum logic [2:0] {IDLE, WAIT_HI, WAIT_LO, RD_LO, RD_HI, DRAIN} state_e;

    state_e        state_q;
    logic [TW-1:0] tcnt_q;
    logic [CW-1:0] chan_q;
    logic [CW-1:0] dchan_q;
    logic [DW-1:0] dout_q;
    logic          valid_q;
    logic          rd_n_q;
    logic          done_q;
    logic          overrun_q;
    logic          acc;
    logic          last;

    assign acc  = valid_q && out_if.dout_ready_i;
    assign last = chan_q == CW'(NCHAN - 1);

`ifdef DAQ_RDSEQ_TIMEOUT_EN
    logic [7:0] wd_q;
    logic       timeout_q;
    logic       wd_hit;
    assign wd_hit = wd_q == 8'(BUSY_TO - 1);
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            tcnt_q    <= '0;
            chan_q    <= '0;
            dchan_q   <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            rd_n_q    <= 1'b1;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef DAQ_RDSEQ_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (start_i && state_q != IDLE) overrun_q <= 1'b1;
            if (acc) valid_q <= 1'b0;
`ifdef DAQ_RDSEQ_TIMEOUT_EN
            wd_q <= ((state_q == WAIT_HI && !busy_i) || (state_q == WAIT_LO && busy_i)) ? wd_q + 8'd1 : 8'd0;
`endif
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= WAIT_HI;
                    chan_q  <= '0;
                end
                WAIT_HI: begin
                    if (busy_i) state_q <= WAIT_LO;
`ifdef DAQ_RDSEQ_TIMEOUT_EN
                    else if (wd_hit) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                    end
`endif
                end
                WAIT_LO: begin
                    if (!busy_i) begin
                        state_q <= RD_LO;
                        rd_n_q  <= 1'b0;
                        tcnt_q  <= '0;
                    end
`ifdef DAQ_RDSEQ_TIMEOUT_EN
                    else if (wd_hit) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                    end
`endif
                end
                // The register is always empty here: RD_LO is only entered once the previous word left.
                RD_LO: if (tcnt_q == TW'(TLOW - 1)) begin
                    state_q <= RD_HI;
                    rd_n_q  <= 1'b1;
                    tcnt_q  <= '0;
                    dout_q  <= data_i;
                    dchan_q <= chan_q;
                    valid_q <= 1'b1;
                end else tcnt_q <= tcnt_q + 1'b1;
                RD_HI: if (tcnt_q < TW'(THIGH - 1)) tcnt_q <= tcnt_q + 1'b1;
                else if (last) state_q <= DRAIN;
                else if (!valid_q || out_if.dout_ready_i) begin
                    state_q <= RD_LO;
                    chan_q  <= chan_q + 1'b1;
                    rd_n_q  <= 1'b0;
                    tcnt_q  <= '0;
                end
                // The last word may already have been taken during RD_HI, so an empty register also ends the frame.
                DRAIN: if (!valid_q || out_if.dout_ready_i) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_n_o              = rd_n_q;
    assign busy_o              = state_q != IDLE;
    assign done_o              = done_q;
    assign overrun_o           = overrun_q;
    assign out_if.dout_o       = dout_q;
    assign out_if.dout_chan_o  = dchan_q;
    assign out_if.dout_valid_o = valid_q;
`ifdef DAQ_RDSEQ_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_daq_read_seq.sv
// tb_daq_read_seq: directed frames with hand-computed expectations for daq_read_seq (default parameters).
module tb_daq_read_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy_in;
    logic [15:0] data;
    logic        rd_n;
    logic        busy_out;
    logic        done;
    logic        overrun;
    logic        timeout;

    int n_vec = 0;
    int n_err = 0;

    daq_read_seq_if #(.DW(16), .CW(3)) bus ();

    daq_read_seq dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .start_i   (start),
        .busy_i    (busy_in),
        .data_i    (data),
        .rd_n_o    (rd_n),
        .busy_o    (busy_out),
        .done_o    (done),
        .overrun_o (overrun),
        .timeout_o (timeout),
        .out_if    (bus)
    );

    always #5 clk = ~clk;

    logic        prev_rd = 1'b1;
    int          lo_len, hi_len, falls, runs, lo_bad, max_hi, min_hi, ndone;
    logic [15:0] words[$];
    logic [2:0]  chans[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        lo_len = 0; hi_len = 0; falls = 0; runs = 0; lo_bad = 0;
        max_hi = 0; min_hi = 1000; ndone = 0;
        words.delete(); chans.delete();
    endtask

    // Strobe shape, accepted words and done pulses; data follows the strobe number.
    always @(negedge clk) begin
        if (rd_n) begin
            if (!prev_rd) begin
                runs++;
                if (lo_len != 3) lo_bad++;
            end
            hi_len++;
        end else begin
            if (prev_rd) begin
                if (falls > 0) begin
                    if (hi_len > max_hi) max_hi = hi_len;
                    if (hi_len < min_hi) min_hi = hi_len;
                end
                falls++;
                data = 16'hA5A0 + 16'(falls - 1);
                lo_len = 0;
                hi_len = 0;
            end
            lo_len++;
        end
        prev_rd = rd_n;
        if (bus.dout_valid_o && bus.dout_ready_i) begin
            words.push_back(bus.dout_o);
            chans.push_back(bus.dout_chan_o);
        end
        if (done) ndone++;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_frame(input string tag);
        int i;
        @(posedge clk); #1 clr();
        pulse_start();
        busy_in = 1'b1;
        repeat (10) @(negedge clk);
        busy_in = 1'b0;
        for (i = 0; i < 600 && ndone == 0; i++) @(negedge clk);
        if (ndone == 0) check({tag, "_done_timeout"}, 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic verify(input string tag);
        check({tag, "_nwords"}, words.size(), 8);
        for (int i = 0; i < 8 && i < words.size(); i++) begin
            check({tag, "_data"}, words[i], 16'hA5A0 + 16'(i));
            check({tag, "_chan"}, chans[i], i);
        end
        check({tag, "_ndone"}, ndone, 1);
        check({tag, "_strobes"}, runs, 8);
        check({tag, "_low_len_bad"}, lo_bad, 0);
        check({tag, "_busy_end"}, busy_out, 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; busy_in = 1'b0; data = '0;
        bus.dout_ready_i = 1'b1;
        clr();
        repeat (3) @(negedge clk);
        check("rst_rd_n", rd_n, 1);
        check("rst_valid", bus.dout_valid_o, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        check("rst_dout", bus.dout_o, 0);
        check("rst_chan", bus.dout_chan_o, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_frame("t1");
        verify("t1");
        check("t1_min_high", min_hi, 2);
        check("t1_max_high", max_hi, 2);
        check("t1_overrun", overrun, 0);

        fork
            run_frame("t3");
            begin
                int i;
                for (i = 0; i < 400 && !(bus.dout_valid_o && bus.dout_chan_o == 3'd2); i++) @(negedge clk);
                bus.dout_ready_i = 1'b0;
                repeat (20) @(negedge clk);
                bus.dout_ready_i = 1'b1;
            end
        join
        verify("t3");
        check("t3_stretched_high", max_hi, 21);

        fork
            run_frame("t4");
            begin
                int i;
                for (i = 0; i < 400 && !(falls == 5 && !rd_n); i++) @(negedge clk);
                pulse_start();
            end
        join
        verify("t4");
        check("t4_overrun", overrun, 1);

        begin
            int i;
            @(posedge clk); #1 clr();
            pulse_start();
            busy_in = 1'b1;
            repeat (10) @(negedge clk);
            busy_in = 1'b0;
            for (i = 0; i < 400 && !(falls == 3 && !rd_n); i++) @(negedge clk);
            check("t5_in_rd_lo", rd_n, 0);
            reset_n = 1'b0;
            #1;
            check("t5_abort_rd_n", rd_n, 1);
            check("t5_abort_valid", bus.dout_valid_o, 0);
            check("t5_abort_busy", busy_out, 0);
            check("t5_abort_overrun", overrun, 0);
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            @(negedge clk);
        end
        run_frame("t5");
        verify("t5");

`ifdef DAQ_RDSEQ_TIMEOUT_EN
        begin
            int i;
            @(posedge clk); #1 clr();
            pulse_start();
            for (i = 0; i < 400 && !timeout; i++) @(negedge clk);
            check("t6_timeout", timeout, 1);
            check("t6_busy", busy_out, 0);
            check("t6_strobes", falls, 0);
            check("t6_done", ndone, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
